// File: rtl/i2s_controller.sv
// I2S bus master receiver: divides clk_in down to sck, drives ws, and assembles
// MSB-first serial data from sd_in into parallel samples with a one-clk valid strobe.
module i2s_controller #(
  parameter int SCK_HALF_PERIOD = 16,
  parameter int SLOT_BITS       = 32,
  parameter int DATA_WIDTH      = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sd_in,
  output logic                  sck,
  output logic                  ws,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  sample_channel
);

  localparam int DIV_W = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;
  localparam int BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH);

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  sd_meta;
  logic                  sd_sync;

  logic sck_tick;
  logic rise_evt;
  logic fall_evt;
  logic capture_bit;
  logic slot_end;

  // Edge events are decoded from the divider, never from the sck output itself.
  always_comb begin
    sck_tick    = (div_cnt == DIV_LAST);
    rise_evt    = sck_tick && !sck;
    fall_evt    = sck_tick && sck;
    capture_bit = (bit_cnt != '0) && (bit_cnt <= DATA_LAST);
    slot_end    = fall_evt && (bit_cnt == BIT_LAST);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (sck_tick) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // sd_in is an off-chip pin; sck edges are many clks apart, so the extra
  // two clks of synchroniser latency are well inside the half period.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
    end else begin
      sd_meta <= sd_in;
      sd_sync <= sd_meta;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bit_cnt        <= '0;
      shift_reg      <= '0;
      ws             <= 1'b0;
      sample_out     <= '0;
      sample_valid   <= 1'b0;
      sample_channel <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (rise_evt && capture_bit) begin
        shift_reg <= (shift_reg << 1) | DATA_WIDTH'(sd_sync);
      end
      if (slot_end) begin
        bit_cnt        <= '0;
        ws             <= ~ws;
        sample_out     <= shift_reg;
        sample_channel <= ws;
        sample_valid   <= 1'b1;
        shift_reg      <= '0;
      end else if (fall_evt) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_controller.sv
// Self-checking bench for i2s_controller: a slot-level device model drives sd_in,
// a scoreboard queue holds expected samples, and a monitor checks pins and strobes.
module tb_i2s_controller;

  localparam int HALF     = 16;
  localparam int SLOT     = 32;
  localparam int DW       = 24;
  localparam int SCK_CLK  = 2 * HALF;
  localparam int SLOT_CLK = SCK_CLK * SLOT;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          sd_in  = 1'b0;
  logic          sck;
  logic          ws;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          sample_channel;

  i2s_controller #(
    .SCK_HALF_PERIOD(HALF),
    .SLOT_BITS      (SLOT),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sd_in         (sd_in),
    .sck           (sck),
    .ws            (ws),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .sample_channel(sample_channel)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- shared state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit active = 1'b0;

  logic [DW:0]   exp_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] dir_q[$];
  bit            junk_q[$];

  logic [DW-1:0] cur_data;
  bit            cur_junk;
  logic [DW-1:0] last_out;
  logic          ws_prev;
  int            trace_err = 0;
  int            hold_err  = 0;
  int            pulses    = 0;
  int            ws_edges  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- device model ----------------
  // Slot position b is driven right after the clk edge where the controller's
  // bit counter becomes b; positions 1..DW carry data MSB first, the rest junk.
  task automatic drive_bit(input int b);
    if (b >= 1 && b <= DW) sd_in = cur_data[DW-b];
    else if (cur_junk)     sd_in = 1'b1;
    else                   sd_in = 1'($urandom_range(0, 1));
  endtask

  task automatic start_slot(input int s);
    logic ch;
    ch = s[0];
    if (dir_q.size() > 0) begin
      cur_data = dir_q.pop_front();
      cur_junk = junk_q.pop_front();
    end else begin
      cur_data = DW'($urandom());
      cur_junk = 1'b0;
    end
    exp_q.push_back({ch, cur_data});
    exp_cyc_q.push_back(SLOT_CLK * (s + 1));
    drive_bit(0);
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (active) begin
        cyc++;
        if (cyc % SLOT_CLK == 0)     start_slot(cyc / SLOT_CLK);
        else if (cyc % SCK_CLK == 0) drive_bit((cyc % SLOT_CLK) / SCK_CLK);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_in) begin
    if (active) begin
      if (sck !== 1'((cyc / HALF) % 2))    trace_err++;
      if (ws  !== 1'((cyc / SLOT_CLK) % 2)) trace_err++;
      if (ws !== ws_prev) ws_edges++;
      ws_prev = ws;
      if (sample_valid) begin
        logic [DW:0] e;
        int          ec;
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("sample_out", 64'(sample_out), 64'(e[DW-1:0]));
          check("sample_channel", 64'(sample_channel), 64'(e[DW]));
          check("valid_time", 64'(cyc), 64'(ec));
          last_out = e[DW-1:0];
        end
      end else if (sample_out !== last_out) begin
        hold_err++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_sck"}, 64'(sck), 64'd0);
    check({tag, "_ws"}, 64'(ws), 64'd0);
    check({tag, "_sample_out"}, 64'(sample_out), 64'd0);
    check({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
    check({tag, "_sample_channel"}, 64'(sample_channel), 64'd0);
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    #2;
    exp_q.delete();
    exp_cyc_q.delete();
    cyc      = 0;
    pulses   = 0;
    ws_edges = 0;
    last_out = '0;
    ws_prev  = 1'b0;
    rst_in   = 1'b1;
    active   = 1'b1;
    start_slot(0);
  endtask

  task automatic segment_checks(input string tag);
    @(negedge clk_in);
    #2;
    check({tag, "_trace_err"}, 64'(trace_err), 64'd0);
    check({tag, "_hold_err"}, 64'(hold_err), 64'd0);
    check({tag, "_pulse_count"}, 64'(pulses), 64'(cyc / SLOT_CLK));
    check({tag, "_ws_edges"}, 64'(ws_edges), 64'(cyc / SLOT_CLK));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    dir_q  = '{24'hA5C3F1, 24'h123456, 24'h000000};
    junk_q = '{1'b0, 1'b0, 1'b1};

    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #2;
    check_reset_outputs("por");
    release_reset();

    repeat (20 * SLOT_CLK + 10) @(posedge clk_in);
    segment_checks("run1");

    // Reset 500 clks into a slot; the partial sample must never appear.
    waited = 0;
    while (cyc % SLOT_CLK != 500 && waited < 2 * SLOT_CLK) begin
      @(negedge clk_in);
      waited++;
    end
    check("midframe_wait_timeout", 64'(cyc % SLOT_CLK), 64'd500);
    #2;
    active = 1'b0;
    rst_in = 1'b0;
    #1;
    check_reset_outputs("mid_async");
    check("mid_pending_slots", 64'(exp_q.size()), 64'd1);
    repeat (4) @(negedge clk_in);
    #2;
    check_reset_outputs("mid_held");

    dir_q.push_back(24'hFFFFFF);
    junk_q.push_back(1'b0);
    dir_q.push_back(24'h000001);
    junk_q.push_back(1'b1);
    release_reset();

    repeat (8 * SLOT_CLK + 10) @(posedge clk_in);
    segment_checks("run2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
